// File: rtl/map_table_nway_ckpt.sv
// N-way register-rename map table with a bounded branch-checkpoint store.
// Renames up to WIDTH instructions per cycle with intra-group bypass, snoops
// NUM_CDB completion buses into the live map and every stored checkpoint, and
// restores the whole map in one cycle on a branch mispredict.
module map_table_nway_ckpt #(
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned NUM_PR   = 64,
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned NUM_CKPT = 4,
    parameter int unsigned ZERO_REG = 31,
    localparam int unsigned AW = $clog2(NUM_ARCH),
    localparam int unsigned PW = $clog2(NUM_PR),
    localparam int unsigned CW = $clog2(NUM_CKPT),
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [WIDTH-1:0]      disp_valid,
    input  logic [WIDTH*AW-1:0]   disp_dest,
    input  logic [WIDTH*PW-1:0]   disp_T,
    input  logic [WIDTH*AW-1:0]   disp_ra,
    input  logic [WIDTH*AW-1:0]   disp_rb,
    input  logic                  br_valid,
    input  logic [BW-1:0]         br_way,
    output logic [WIDTH*PW-1:0]   T1,
    output logic [WIDTH*PW-1:0]   T2,
    output logic [WIDTH-1:0]      T1_ready,
    output logic [WIDTH-1:0]      T2_ready,
    output logic [WIDTH*PW-1:0]   Told,
    output logic                  disp_stall,
    output logic [CW-1:0]         ckpt_id,
    input  logic [NUM_CDB-1:0]    cdb_valid,
    input  logic [NUM_CDB*PW-1:0] cdb_T,
    input  logic                  res_valid,
    input  logic [CW-1:0]         res_id,
    input  logic                  res_mispredict,
    output logic [CW:0]           ckpt_free_cnt
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [PW-1:0]       map_tag_q [NUM_ARCH];
    logic [PW-1:0]       map_tag_d [NUM_ARCH];
    logic [NUM_ARCH-1:0] map_rdy_q, map_rdy_d;

    logic [PW-1:0]       ck_tag_q [NUM_CKPT][NUM_ARCH];
    logic [PW-1:0]       ck_tag_d [NUM_CKPT][NUM_ARCH];
    logic [NUM_ARCH-1:0] ck_rdy_q [NUM_CKPT];
    logic [NUM_ARCH-1:0] ck_rdy_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] ck_young_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] ck_young_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] ck_valid_q, ck_valid_d;

    logic [PW-1:0]       snap_tag [NUM_ARCH];
    logic [NUM_ARCH-1:0] snap_rdy;
    logic [NUM_PR-1:0]   pr_done;
    logic [CW:0]         free_cnt;
    logic [CW-1:0]       alloc_id;
    logic [NUM_CKPT-1:0] free_mask;
    logic                do_alloc, do_resolve, do_restore;
    logic [AW-1:0]       lk_r, dest_j;
    logic [PW-1:0]       lk_tag;
    logic                lk_rdy;

    // Completion decode, free count, lowest free ID and stall.
    always_comb begin
        pr_done = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k]) pr_done[cdb_T[k*PW +: PW]] = 1'b1;
        end
        free_cnt = (CW+1)'(NUM_CKPT);
        alloc_id = '0;
        for (int e = int'(NUM_CKPT) - 1; e >= 0; e--) begin
            if (ck_valid_q[e]) free_cnt = free_cnt - (CW+1)'(1);
            else               alloc_id = CW'(e);
        end
        disp_stall    = (br_valid && free_cnt == '0) || (res_valid && res_mispredict);
        ckpt_free_cnt = free_cnt;
        ckpt_id       = alloc_id;
        do_alloc      = br_valid && !disp_stall;
        do_resolve    = res_valid && ck_valid_q[res_id];
        do_restore    = do_resolve && res_mispredict;
    end

    // Source/Told lookup with youngest-earlier-way override and CDB ready bypass.
    always_comb begin
        T1 = '0; T2 = '0; Told = '0; T1_ready = '0; T2_ready = '0;
        lk_r = '0; lk_tag = '0; lk_rdy = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            for (int s = 0; s < 3; s++) begin
                lk_r   = (s == 0) ? disp_ra[j*AW +: AW] :
                         (s == 1) ? disp_rb[j*AW +: AW] : disp_dest[j*AW +: AW];
                lk_tag = map_tag_q[lk_r];
                lk_rdy = map_rdy_q[lk_r] | pr_done[lk_tag];
                for (int i = 0; i < j; i++) begin
                    if (disp_valid[i] && disp_dest[i*AW +: AW] == lk_r && lk_r != ZR) begin
                        lk_tag = disp_T[i*PW +: PW];
                        lk_rdy = 1'b0;
                    end
                end
                if (lk_r == ZR) begin
                    lk_tag = map_tag_q[ZR];
                    lk_rdy = 1'b1;
                end
                if (s == 0) begin
                    T1[j*PW +: PW] = lk_tag;
                    T1_ready[j]    = lk_rdy;
                end else if (s == 1) begin
                    T2[j*PW +: PW] = lk_tag;
                    T2_ready[j]    = lk_rdy;
                end else begin
                    Told[j*PW +: PW] = lk_tag;
                end
            end
        end
    end

    // Next map and checkpoint store: restore or CDB+rename, snoop, free, allocate.
    always_comb begin
        map_tag_d  = map_tag_q;
        map_rdy_d  = map_rdy_q;
        ck_tag_d   = ck_tag_q;
        ck_rdy_d   = ck_rdy_q;
        ck_young_d = ck_young_q;
        ck_valid_d = ck_valid_q;
        snap_tag   = map_tag_q;
        snap_rdy   = map_rdy_q;
        free_mask  = '0;
        dest_j     = '0;

        if (do_restore) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                map_tag_d[a] = ck_tag_q[res_id][a];
                map_rdy_d[a] = ck_rdy_q[res_id][a] | pr_done[ck_tag_q[res_id][a]];
            end
        end else begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                map_rdy_d[a] = map_rdy_q[a] | pr_done[map_tag_q[a]];
            end
            snap_rdy = map_rdy_d;
            if (!disp_stall) begin
                for (int j = 0; j < WIDTH; j++) begin
                    dest_j = disp_dest[j*AW +: AW];
                    if (disp_valid[j] && dest_j != ZR) begin
                        map_tag_d[dest_j] = disp_T[j*PW +: PW];
                        map_rdy_d[dest_j] = 1'b0;
                        // The checkpoint sees only the branch and older ways.
                        if (j <= int'(br_way)) begin
                            snap_tag[dest_j] = disp_T[j*PW +: PW];
                            snap_rdy[dest_j] = 1'b0;
                        end
                    end
                end
            end
        end
        map_rdy_d[ZR] = 1'b1;

        for (int e = 0; e < NUM_CKPT; e++) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                if (pr_done[ck_tag_q[e][a]]) ck_rdy_d[e][a] = 1'b1;
            end
        end

        if (do_resolve) begin
            free_mask[res_id] = 1'b1;
            if (res_mispredict) free_mask = free_mask | ck_young_q[res_id];
        end
        ck_valid_d = ck_valid_q & ~free_mask;
        for (int e = 0; e < NUM_CKPT; e++) begin
            ck_young_d[e] = ck_young_q[e] & ~free_mask;
        end

        if (do_alloc) begin
            for (int e = 0; e < NUM_CKPT; e++) begin
                if (ck_valid_q[e]) ck_young_d[e][alloc_id] = 1'b1;
            end
            ck_valid_d[alloc_id]   = 1'b1;
            ck_young_d[alloc_id]   = '0;
            ck_tag_d[alloc_id]     = snap_tag;
            ck_rdy_d[alloc_id]     = snap_rdy;
            ck_rdy_d[alloc_id][ZR] = 1'b1;
        end
    end

    // State registers; synchronous reset restores the identity map, no checkpoints.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                map_tag_q[a] <= PW'(a);
                for (int e = 0; e < NUM_CKPT; e++) ck_tag_q[e][a] <= PW'(a);
            end
            map_rdy_q  <= '1;
            ck_valid_q <= '0;
            for (int e = 0; e < NUM_CKPT; e++) begin
                ck_rdy_q[e]   <= '1;
                ck_young_q[e] <= '0;
            end
        end else if (en) begin
            map_tag_q  <= map_tag_d;
            map_rdy_q  <= map_rdy_d;
            ck_tag_q   <= ck_tag_d;
            ck_rdy_q   <= ck_rdy_d;
            ck_young_q <= ck_young_d;
            ck_valid_q <= ck_valid_d;
        end
    end

    // Resolving an ID that holds no checkpoint is a caller bug.
    always_ff @(posedge clock) begin
        if (!reset && en && res_valid) begin
            assert (ck_valid_q[res_id])
            else $error("resolve of non-valid checkpoint id %0d", res_id);
        end
    end

endmodule

// File: tb/tb_map_table_nway_ckpt.sv
// Directed bench for map_table_nway_ckpt: rename bypass, CDB bypass,
// checkpoint allocate/restore/release, zero register and mid-run reset.
module tb_map_table_nway_ckpt;

    logic        clock, reset, en;
    logic [1:0]  disp_valid;
    logic [9:0]  disp_dest, disp_ra, disp_rb;
    logic [11:0] disp_T;
    logic        br_valid;
    logic [0:0]  br_way;
    logic [11:0] T1, T2, Told;
    logic [1:0]  T1_ready, T2_ready;
    logic        disp_stall;
    logic [1:0]  ckpt_id;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_T;
    logic        res_valid, res_mispredict;
    logic [1:0]  res_id;
    logic [2:0]  ckpt_free_cnt;

    int errors = 0;
    int checks = 0;

    map_table_nway_ckpt dut (
        .clock(clock), .reset(reset), .en(en),
        .disp_valid(disp_valid), .disp_dest(disp_dest), .disp_T(disp_T),
        .disp_ra(disp_ra), .disp_rb(disp_rb),
        .br_valid(br_valid), .br_way(br_way),
        .T1(T1), .T2(T2), .T1_ready(T1_ready), .T2_ready(T2_ready), .Told(Told),
        .disp_stall(disp_stall), .ckpt_id(ckpt_id),
        .cdb_valid(cdb_valid), .cdb_T(cdb_T),
        .res_valid(res_valid), .res_id(res_id), .res_mispredict(res_mispredict),
        .ckpt_free_cnt(ckpt_free_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic idle();
        en = 1'b1; disp_valid = '0; disp_dest = '0; disp_T = '0; disp_ra = '0;
        disp_rb = '0; br_valid = 1'b0; br_way = '0; cdb_valid = '0; cdb_T = '0;
        res_valid = 1'b0; res_id = '0; res_mispredict = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    // Observe map[r] through way-0 source A with nothing else active.
    task automatic peek_chk(input string name, input logic [4:0] r,
                            input logic [5:0] exp_tag, input logic exp_rdy);
        idle();
        disp_ra = {5'd0, r};
        #1;
        chk({name, "_tag"}, 32'(T1[5:0]), 32'(exp_tag));
        chk({name, "_rdy"}, 32'(T1_ready[0]), 32'(exp_rdy));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state.
        #1;
        chk("reset_cnt", 32'(ckpt_free_cnt), 4);
        chk("reset_stall", 32'(disp_stall), 0);
        peek_chk("reset_r3", 5'd3, 6'd3, 1'b1);

        // Intra-group bypass: way0 r3->P40, way1 reads r3 and renames r3->P41.
        disp_valid = 2'b11; disp_dest = {5'd3, 5'd3}; disp_T = {6'd41, 6'd40};
        disp_ra = {5'd3, 5'd0}; disp_rb = {5'd0, 5'd0};
        #1;
        chk("byp_w1_T1", 32'(T1[11:6]), 40);
        chk("byp_w1_T1rdy", 32'(T1_ready[1]), 0);
        chk("byp_w1_Told", 32'(Told[11:6]), 40);
        chk("byp_w0_Told", 32'(Told[5:0]), 3);
        chk("byp_w1_T2", 32'(T2[11:6]), 0);
        chk("byp_w1_T2rdy", 32'(T2_ready[1]), 1);
        tick();
        peek_chk("after_r3", 5'd3, 6'd41, 1'b0);

        // CDB ready bypass for a not-ready source.
        disp_valid = 2'b01; disp_dest = {5'd0, 5'd5}; disp_T = {6'd0, 6'd50};
        tick();
        peek_chk("r5_pending", 5'd5, 6'd50, 1'b0);
        disp_ra = {5'd0, 5'd5}; cdb_valid = 2'b10; cdb_T = {6'd50, 6'd0};
        #1;
        chk("cdb_byp_rdy", 32'(T1_ready[0]), 1);
        tick();
        peek_chk("r5_done", 5'd5, 6'd50, 1'b1);

        // Branch at way0, way1 renames r7; checkpoint snoops P45; mispredict restores.
        disp_valid = 2'b01; disp_dest = {5'd0, 5'd8}; disp_T = {6'd0, 6'd45};
        tick();
        disp_valid = 2'b10; disp_dest = {5'd7, 5'd0}; disp_T = {6'd60, 6'd0};
        br_valid = 1'b1; br_way = 1'b0;
        #1;
        chk("br_id0", 32'(ckpt_id), 0);
        chk("br_nostall", 32'(disp_stall), 0);
        tick();
        #1;
        chk("br_cnt", 32'(ckpt_free_cnt), 3);
        peek_chk("r7_renamed", 5'd7, 6'd60, 1'b0);
        cdb_valid = 2'b01; cdb_T = {6'd0, 6'd45};
        tick();
        res_valid = 1'b1; res_id = 2'd0; res_mispredict = 1'b1;
        #1;
        chk("misp_stall", 32'(disp_stall), 1);
        tick();
        peek_chk("r7_restored", 5'd7, 6'd7, 1'b1);
        peek_chk("r8_restored", 5'd8, 6'd45, 1'b1);
        chk("misp_cnt", 32'(ckpt_free_cnt), 4);

        // Exhaust the store; release id 2 and reuse it the following cycle.
        for (int i = 0; i < 4; i++) begin
            br_valid = 1'b1;
            #1;
            chk("fill_id", 32'(ckpt_id), 32'(i));
            tick();
        end
        br_valid = 1'b1; res_valid = 1'b1; res_id = 2'd2; res_mispredict = 1'b0;
        #1;
        chk("full_stall", 32'(disp_stall), 1);
        chk("full_cnt", 32'(ckpt_free_cnt), 0);
        tick();
        br_valid = 1'b1;
        #1;
        chk("reuse_stall", 32'(disp_stall), 0);
        chk("reuse_id", 32'(ckpt_id), 2);
        chk("reuse_cnt", 32'(ckpt_free_cnt), 1);
        tick();
        #1;
        chk("refull_cnt", 32'(ckpt_free_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_id = 2'(i);
            tick();
        end
        #1;
        chk("drain_cnt", 32'(ckpt_free_cnt), 4);

        // Nested branches 0,1,2; mispredicting 1 also squashes 2.
        br_valid = 1'b1;
        #1;
        chk("nest_id0", 32'(ckpt_id), 0);
        tick();
        br_valid = 1'b1; br_way = 1'b0;
        disp_valid = 2'b10; disp_dest = {5'd9, 5'd0}; disp_T = {6'd20, 6'd0};
        #1;
        chk("nest_id1", 32'(ckpt_id), 1);
        tick();
        br_valid = 1'b1;
        #1;
        chk("nest_id2", 32'(ckpt_id), 2);
        tick();
        #1;
        chk("nest_cnt", 32'(ckpt_free_cnt), 1);
        peek_chk("r9_renamed", 5'd9, 6'd20, 1'b0);
        res_valid = 1'b1; res_id = 2'd1; res_mispredict = 1'b1;
        tick();
        #1;
        chk("squash_cnt", 32'(ckpt_free_cnt), 3);
        peek_chk("r9_restored", 5'd9, 6'd9, 1'b1);
        res_valid = 1'b1; res_id = 2'd0; res_mispredict = 1'b0;
        tick();
        #1;
        chk("final_cnt", 32'(ckpt_free_cnt), 4);

        // Zero register is never renamed and always ready.
        disp_valid = 2'b01; disp_dest = {5'd0, 5'd31}; disp_T = {6'd0, 6'd33};
        disp_ra = {5'd31, 5'd0};
        #1;
        chk("zero_Told", 32'(Told[5:0]), 31);
        chk("zero_src_T1", 32'(T1[11:6]), 31);
        chk("zero_src_rdy", 32'(T1_ready[1]), 1);
        tick();
        peek_chk("zero_map", 5'd31, 6'd31, 1'b1);

        // en=0 holds state.
        en = 1'b0; disp_valid = 2'b01; disp_dest = {5'd0, 5'd10}; disp_T = {6'd0, 6'd11};
        tick();
        peek_chk("hold_r10", 5'd10, 6'd10, 1'b1);

        // Reset in the middle of activity.
        disp_valid = 2'b01; disp_dest = {5'd0, 5'd3}; disp_T = {6'd0, 6'd50};
        br_valid = 1'b1;
        tick();
        #1;
        chk("pre_rst_cnt", 32'(ckpt_free_cnt), 3);
        reset = 1'b1; br_valid = 1'b1;
        tick();
        reset = 1'b0;
        peek_chk("rst_r3", 5'd3, 6'd3, 1'b1);
        peek_chk("rst_r9", 5'd9, 6'd9, 1'b1);
        chk("rst_cnt", 32'(ckpt_free_cnt), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
